// File: rtl/edge_pkg.sv
// edge_pkg: luma weights, loader FSM states and frame-size helper shared by the gray front end.
package edge_pkg;
    localparam int W_R = 77;
    localparam int W_G = 150;
    localparam int W_B = 29;

    typedef enum logic [2:0] {FILL, CONV_DRAIN, START, STREAM, WAIT_DONE} state_t;

    function automatic int frame_size(input int x, input int y);
        return x * y;
    endfunction
endpackage

// File: rtl/rgb2gray_pix.sv
// rgb2gray_pix: single registered RGB->luma stage carrying a write-address tag.
// Define RGB2GRAY_ROUND_EN to round to nearest instead of truncating.
module rgb2gray_pix
    import edge_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    input  logic [23:0]   in_data_i,
    input  logic [AW-1:0] in_addr_i,
    output logic          out_valid_o,
    output logic [7:0]    out_gray_o,
    output logic [AW-1:0] out_addr_o
);
    logic [15:0] sum;

`ifdef RGB2GRAY_ROUND_EN
    assign sum = 16'(W_R * int'(in_data_i[23:16]) + W_G * int'(in_data_i[15:8])
                     + W_B * int'(in_data_i[7:0]) + 128);
`else
    assign sum = 16'(W_R * int'(in_data_i[23:16]) + W_G * int'(in_data_i[15:8])
                     + W_B * int'(in_data_i[7:0]));
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            out_gray_o  <= '0;
            out_addr_o  <= '0;
        end else begin
            out_valid_o <= in_valid_i;
            out_gray_o  <= sum[15:8];
            out_addr_o  <= in_addr_i;
        end
    end
endmodule

// File: rtl/rgb2gray_frame_loader.sv
// rgb2gray_frame_loader: buffers one RGB frame as luma, then streams it gap-free after a start pulse.
// Luma rounding is selected at build time with RGB2GRAY_ROUND_EN (see rgb2gray_pix).
module rgb2gray_frame_loader
    import edge_pkg::*;
#(
    parameter int IMG_X_SIZE = 3,
    parameter int IMG_Y_SIZE = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [23:0] in_data_i,
    input  logic        in_sop_i,
    input  logic        in_eop_i,
    input  logic        done_i,
    output logic        start_o,
    output logic [7:0]  gray_o,
    output logic        gray_valid_o,
    output logic        frame_err_o
);
    localparam int N  = frame_size(IMG_X_SIZE, IMG_Y_SIZE);
    localparam int PW = $clog2(N + 1);
    localparam logic [PW-1:0] LAST = PW'(N - 1);
    localparam logic [PW-1:0] FULL = PW'(N);

    state_t         state;
    logic [PW-1:0]  wr_ptr, rd_ptr, idx, pix_addr;
    logic [7:0]     pix_buf [N];
    logic [7:0]     pix_gray;
    logic           acc, keep, last, early, beat_err, pix_valid;

    // A beat carrying sop always restarts the frame; a non-sop beat at slot 0 has no frame to join.
    always_comb begin
        acc      = in_valid_i && in_ready_o;
        idx      = in_sop_i ? '0 : wr_ptr;
        keep     = in_sop_i || wr_ptr != '0;
        last     = idx == LAST;
        early    = in_eop_i && !last;
        beat_err = !keep || (in_sop_i && wr_ptr != '0) || early || (last && !in_eop_i);
    end

    rgb2gray_pix #(.AW(PW)) u_pix (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (acc && keep && !early),
        .in_data_i   (in_data_i),
        .in_addr_i   (idx),
        .out_valid_o (pix_valid),
        .out_gray_o  (pix_gray),
        .out_addr_o  (pix_addr)
    );

    always_ff @(posedge clk_i) begin
        if (pix_valid) pix_buf[pix_addr] <= pix_gray;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= FILL;
            in_ready_o   <= 1'b0;
            start_o      <= 1'b0;
            gray_o       <= '0;
            gray_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            start_o <= 1'b0;
            case (state)
                FILL: begin
                    in_ready_o <= !(acc && keep && last);
                    if (acc) begin
                        if (beat_err) frame_err_o <= 1'b1;
                        wr_ptr <= (!keep || early) ? '0 : idx + 1'b1;
                        if (keep && last) state <= CONV_DRAIN;
                    end
                end
                CONV_DRAIN: begin
                    start_o <= 1'b1;
                    state   <= START;
                end
                // Pixel 0 is issued here so the stream begins the cycle right after start_o.
                START: begin
                    gray_o       <= pix_buf[0];
                    gray_valid_o <= 1'b1;
                    rd_ptr       <= PW'(1);
                    state        <= STREAM;
                end
                STREAM: begin
                    if (rd_ptr == FULL) begin
                        gray_o       <= '0;
                        gray_valid_o <= 1'b0;
                        state        <= WAIT_DONE;
                    end else begin
                        gray_o <= pix_buf[rd_ptr];
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (done_i) begin
                        wr_ptr     <= '0;
                        in_ready_o <= 1'b1;
                        state      <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_rgb2gray_frame_loader.sv
// tb_rgb2gray_frame_loader: directed frames with a queue scoreboard checked by an output monitor.
module tb_rgb2gray_frame_loader;
    localparam int N = 9;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, done = 1'b0;
    logic [23:0] in_data = '0;
    logic        in_ready, start, gray_valid, frame_err;
    logic [7:0]  gray;

    int n_cmp = 0, n_err = 0, cyc = 0, last_acc = 0, pend = 0, pix_seen = 0, start_cnt = 0;
    logic [7:0]  sb [$];
    logic [23:0] fpx [N];
    logic [7:0]  fex [N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    rgb2gray_frame_loader #(.IMG_X_SIZE(3), .IMG_Y_SIZE(3)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .in_sop_i     (in_sop),
        .in_eop_i     (in_eop),
        .done_i       (done),
        .start_o      (start),
        .gray_o       (gray),
        .gray_valid_o (gray_valid),
        .frame_err_o  (frame_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Start must appear two cycles after the cycle of the last accepted beat,
    // i.e. at the negedge following the next rising edge; then N gap-free pixels.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (start) begin
                chk("start_timing", cyc, last_acc + 1);
                pend = N;
                pix_seen = 0;
                start_cnt++;
            end else if (pend > 0) begin
                chk("stream_gap", gray_valid, 1);
                pend--;
            end
            if (gray_valid) begin
                pix_seen++;
                if (sb.size() == 0) begin
                    chk("unexpected_pixel", gray, -1);
                end else begin
                    automatic logic [7:0] e = sb.pop_front();
                    chk("gray_pixel", gray, e);
                end
            end else begin
                chk("gray_idle_zero", gray, 0);
            end
        end
    end

    task automatic send(input logic [23:0] d, input logic sop, input logic eop);
        int w = 0;
        in_valid = 1'b1; in_data = d; in_sop = sop; in_eop = eop;
        while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
        if (w >= 200) chk("ready_timeout", 0, 1);
        @(posedge clk); #1;
        last_acc = cyc;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic send_frame(input bit gap);
        foreach (fex[i]) sb.push_back(fex[i]);
        for (int i = 0; i < N; i++) begin
            send(fpx[i], i == 0, i == N - 1);
            if (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic finish_frame(input bit pulse);
        int w = 0;
        while ((sb.size() != 0 || gray_valid || pend != 0) && w < 100) begin @(posedge clk); #1; w++; end
        chk("stream_end_in_time", int'(w < 100), 1);
        if (pulse) begin done = 1'b1; @(posedge clk); #1; done = 1'b0; end
    endtask

    task automatic set_ramp();
        for (int i = 0; i < N; i++) begin
            automatic logic [7:0] v = 8'(10 * (i + 1));
            fpx[i] = {v, v, v};
            fex[i] = v;
        end
    endtask

    task automatic set_const(input logic [23:0] d, input logic [7:0] e);
        for (int i = 0; i < N; i++) begin fpx[i] = d; fex[i] = e; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen, s0, w;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_start", start, 0);
        chk("rst_gray", gray, 0);
        chk("rst_gray_valid", gray_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 chk("ready_before_first_clk", in_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_first_clk", in_ready, 1);

        set_ramp(); send_frame(0); finish_frame(1);
        chk("ramp_no_err", frame_err, 0);

`ifdef RGB2GRAY_ROUND_EN
        set_const({8'd255, 8'd0, 8'd0}, 8'd77);
`else
        set_const({8'd255, 8'd0, 8'd0}, 8'd76);
`endif
        send_frame(0); finish_frame(1);
        set_const({8'd255, 8'd255, 8'd255}, 8'd255);
        send_frame(0); finish_frame(1);

        // Mixed colours with in_valid low every other cycle.
        fpx[0] = {8'd200, 8'd100, 8'd50};  fex[0] = 8'd124;
        fpx[1] = {8'd0, 8'd255, 8'd0};     fex[1] = 8'd149;
        fpx[2] = {8'd0, 8'd0, 8'd255};
        fpx[3] = {8'd100, 8'd100, 8'd100}; fex[3] = 8'd100;
        fpx[4] = {8'd0, 8'd0, 8'd0};       fex[4] = 8'd0;
        fpx[5] = {8'd255, 8'd255, 8'd255}; fex[5] = 8'd255;
        fpx[6] = {8'd50, 8'd60, 8'd70};    fex[6] = 8'd58;
        fpx[7] = {8'd30, 8'd200, 8'd10};   fex[7] = 8'd127;
        fpx[8] = {8'd128, 8'd64, 8'd32};
`ifdef RGB2GRAY_ROUND_EN
        fex[2] = 8'd29; fex[8] = 8'd80;
`else
        fex[2] = 8'd28; fex[8] = 8'd79;
`endif
        send_frame(1); finish_frame(1);
        chk("gapped_no_err", frame_err, 0);

        // Next frame offered while streaming/waiting must stall until done.
        set_ramp(); send_frame(0);
        in_valid = 1'b1; in_data = 24'h0a0a0a; in_sop = 1'b1;
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (in_ready) seen++; end
        chk("ready_held_low", seen, 0);
        in_valid = 1'b0; in_sop = 1'b0;
        finish_frame(0);
        chk("ready_low_before_done", in_ready, 0);
        done = 1'b1; @(posedge clk); #1; done = 1'b0;
        chk("ready_after_done", in_ready, 1);
        set_const({8'd255, 8'd255, 8'd255}, 8'd255);
        send_frame(0); finish_frame(1);

        // Short frame: eop on beat 5.
        s0 = start_cnt;
        for (int i = 0; i < 5; i++) send({3{8'(10 * (i + 1))}}, i == 0, i == 4);
        repeat (10) @(posedge clk);
        #1;
        chk("short_no_start", start_cnt, s0);
        chk("short_frame_err", frame_err, 1);
        chk("short_still_ready", in_ready, 1);
        set_ramp(); send_frame(0); finish_frame(1);
        chk("recovered_stream", start_cnt, s0 + 1);

        // Reset during pixel 4 of a stream.
        pix_seen = 0;
        set_ramp(); send_frame(0);
        w = 0;
        while (pix_seen < 4 && w < 50) begin @(negedge clk); #1; w++; end
        chk("reach_pixel4", pix_seen, 4);
        rst_n = 1'b0;
        #1;
        chk("midrst_gray_valid", gray_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_gray", gray, 0);
        chk("midrst_frame_err", frame_err, 0);
        sb.delete();
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_midrst", in_ready, 1);
        set_ramp(); send_frame(0); finish_frame(1);
        chk("fresh_no_err", frame_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rgb2gray_frame_loader.md
# rgb2gray_frame_loader

Upstream feeder for the edge detector. Accepts 24-bit RGB pixels over an Avalon-ST sink, converts each to 8-bit luma, and buffers one full IMG_X_SIZE×IMG_Y_SIZE frame. It then emits a one-cycle start pulse followed by one gray pixel per clock with no gaps, which is the contiguous stream the edge detector requires. It holds off the next frame until the detector signals completion.

## Interface
- IMG_X_SIZE, 3, frame width in pixels
- IMG_Y_SIZE, 3, frame height in pixels
- clk_i  in  1  single clock, rising edge
- rst_ni  in  1  reset, asynchronous assert, active-low
- in_valid_i  in  1  Avalon-ST sink valid
- in_ready_o  out  1  Avalon-ST sink ready
- in_data_i  in  24  R[23:16], G[15:8], B[7:0]
- in_sop_i  in  1  start of packet, first pixel of frame
- in_eop_i  in  1  end of packet, last pixel of frame
- done_i  in  1  frame-complete pulse from edge detector (its valid output)
- start_o  out  1  one-cycle pulse to edge detector start input
- gray_o  out  8  gray pixel to edge detector pixel input
- gray_valid_o  out  1  high on each cycle gray_o carries a frame pixel
- frame_err_o  out  1  sticky framing-error flag, cleared only by reset

## Operation
- N = IMG_X_SIZE*IMG_Y_SIZE. Buffer: N×8 register array. Write pointer and read pointer are each $clog2(N+1) bits.
- Beat accepted when in_valid_i && in_ready_o.
- Conversion: sum = 77·R + 150·G + 29·B, 16 bits, max 65280; gray = sum[15:8]. No saturation needed.
- FSM states: FILL, CONV_DRAIN, START, STREAM, WAIT_DONE.
- FILL:
  - in_ready_o = 1 while the accepted count < N.
  - Each accepted beat is converted through one register stage and written to buf[wr_ptr] on the following cycle.
  - in_sop_i on a beat with wr_ptr≠0: set frame_err_o, restart the frame with this beat as pixel 0.
  - Beat with in_sop_i low at wr_ptr=0: discarded, frame_err_o set.
  - in_eop_i before beat N: set frame_err_o, discard the partial frame, wr_ptr←0.
  - Beat N without in_eop_i: set frame_err_o, frame is still used.
  - After beat N is accepted: go to CONV_DRAIN; in_ready_o drops the same cycle.
- CONV_DRAIN: one cycle for the last write to land, then START.
- START: start_o=1 for exactly one cycle, rd_ptr←0, then STREAM.
- STREAM: N consecutive cycles with gray_valid_o=1 and gray_o=buf[rd_ptr], rd_ptr incrementing; after pixel N-1, go to WAIT_DONE.
- WAIT_DONE: idle until done_i=1, then FILL with wr_ptr←0. done_i is ignored in all other states.
- in_ready_o = 0 in every state except FILL.

## Timing
- Reset values: in_ready_o=0, start_o=0, gray_o=0, gray_valid_o=0, frame_err_o=0, state FILL. in_ready_o rises on the first clock after reset release.
- Last input beat accepted at cycle t: start_o high at t+2; first pixel at t+3; last pixel at t+2+N.
- gray_o and gray_valid_o are registered outputs; gray_o=0 whenever gray_valid_o=0.
- Reset asserted mid-STREAM: outputs return to reset values immediately (asynchronous), buffer contents are don't-care, and the frame is lost.
- done_i arriving in the same cycle as the last STREAM pixel is ignored; the detector must pulse done_i after the stream ends.
- Back-to-back input beats are sustained at 1 pixel/clock during FILL. in_valid_i gaps only delay the fill; they never create gaps in STREAM.

## Configuration
- RGB2GRAY_ROUND_EN defined: sum + 128 before taking bits [15:8]; max 65408, still 16 bits.
- RGB2GRAY_ROUND_EN undefined: truncation only.
- No other behaviour differs.

## Structure
- Shared package edge_pkg:
  - luma weight constants W_R=77, W_G=150, W_B=29
  - FSM state enum
  - frame-size helper function N = X·Y
- One sub-module, rgb2gray_pix: registered single-stage RGB→gray converter with an input-valid/output-valid pair; it carries the RGB2GRAY_ROUND_EN ifdef.
- Top level holds the FSM, the buffer and the pointers.

## Test plan
- Nine beats (10,10,10)…(90,90,90), sop on beat 1, eop on beat 9 → start_o one cycle, then gray_o = 10,20,…,90 on 9 consecutive cycles; frame_err_o=0.
- Pure red (255,0,0) frame → gray_o=76 without the macro, 77 with RGB2GRAY_ROUND_EN; white (255,255,255) → 255 in both builds.
- in_valid_i toggled every other cycle during fill → STREAM still 9 gap-free cycles; start_o 2 cycles after the 9th accepted beat.
- eop on beat 5 → frame_err_o=1, no start_o; the next clean 9-beat frame streams correctly.
- Second frame offered during STREAM/WAIT_DONE → in_ready_o=0 until a done_i pulse, then accepted.
- rst_ni pulsed low during STREAM pixel 4 → gray_valid_o=0 and in_ready_o=0 asynchronously; after release, a fresh frame streams normally.
